// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard controller.
// Produces the decode forwarding selects, single-cycle bubbles for load-use
// and branch-operand hazards, and sequences the LWCP coprocessor handshake
// that freezes the whole pipeline until the coprocessor answers or times out.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_BRANCH,
    input  logic             ID_JUMPR,
    input  logic             ID_MEM_WRITE,
    input  logic             ID_I_TYPE,
    input  logic [4:0]       ID_EX_RD,
    input  logic             ID_EX_REG_WRITE,
    input  logic             ID_EX_MEM_READ,
    input  logic [4:0]       EX_MEM_RD,
    input  logic             EX_MEM_REG_WRITE,
    input  logic             EX_MEM_MEM_READ,
    input  logic             EX_MEM_LWCP,
    input  logic             CP_ACK,
    output logic             STALL,
    output logic             PC_HOLD,
    output logic             FORWARD_DECODE_A,
    output logic             FORWARD_DECODE_B,
    output logic             LWCP_STALL,
    output logic             CP_REQ,
    output logic             CP_ERR,
    output logic [CNT_W-1:0] STALL_CNT
);

    // The WAIT timer holds the number of WAIT cycles already completed, so the
    // abort fires on the TIMEOUT-th WAIT cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lwcp_state_t;

    lwcp_state_t      state_q, state_d;
    logic [15:0]      timer_q, timer_d;
    logic             cp_err_q, cp_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic useRs2;
    logic ctrlFlow;
    logic rs1ExHit, rs2ExHit;
    logic rs1MemHit, rs2MemHit;
    logic hzEx, hzMem;
    logic fwdA, fwdB;
    logic freeze;
    logic busy;

    // Operand usage and register-match detection for both hazard classes and
    // for forwarding; x0 never matches because a zero source is rejected.
    always_comb begin
        useRs2    = ID_BRANCH | ID_MEM_WRITE | (~ID_I_TYPE & ~ID_JUMPR);
        ctrlFlow  = ID_BRANCH | ID_JUMPR;
        rs1ExHit  = (ID_RS1 != 5'd0) && (ID_RS1 == ID_EX_RD);
        rs2ExHit  = useRs2 && (ID_RS2 != 5'd0) && (ID_RS2 == ID_EX_RD);
        rs1MemHit = (ID_RS1 != 5'd0) && (ID_RS1 == EX_MEM_RD);
        rs2MemHit = useRs2 && (ID_RS2 != 5'd0) && (ID_RS2 == EX_MEM_RD);
        hzEx      = ID_EX_REG_WRITE && (rs1ExHit || rs2ExHit)
                    && (ctrlFlow || ID_EX_MEM_READ);
        hzMem     = ctrlFlow && EX_MEM_MEM_READ && (rs1MemHit || rs2MemHit);
        fwdA      = EX_MEM_REG_WRITE && !EX_MEM_MEM_READ
                    && (EX_MEM_RD != 5'd0) && (EX_MEM_RD == ID_RS1);
        fwdB      = EX_MEM_REG_WRITE && !EX_MEM_MEM_READ
                    && (EX_MEM_RD != 5'd0) && (EX_MEM_RD == ID_RS2);
    end

    // LWCP sequencing: detect in IDLE, one REQ cycle, WAIT for ACK or timeout,
    // then one DONE cycle that lets the LWCP instruction leave MEM.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cp_err_d = cp_err_q;
        case (state_q)
            S_IDLE: begin
                timer_d = 16'd0;
                if (EX_MEM_LWCP) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                timer_d = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (CP_ACK) begin
                    state_d = S_DONE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    cp_err_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; every combinational output is held low while in reset,
    // and the LWCP freeze suppresses hazard bubbles until it releases.
    always_comb begin
        busy             = (state_q == S_REQ) || (state_q == S_WAIT);
        freeze           = busy || ((state_q == S_IDLE) && EX_MEM_LWCP);
        LWCP_STALL       = rst_n && freeze;
        CP_REQ           = rst_n && busy;
        STALL            = rst_n && (hzEx || hzMem) && !freeze;
        PC_HOLD          = STALL;
        FORWARD_DECODE_A = rst_n && fwdA;
        FORWARD_DECODE_B = rst_n && fwdB;
        CP_ERR           = cp_err_q;
        STALL_CNT        = stall_cnt_q;
    end

    // Saturating count of every cycle spent in a bubble or a freeze.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((STALL || LWCP_STALL) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= 16'd0;
            cp_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cp_err_q    <= cp_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus a randomized run against a
// behavioural model of the hazard and LWCP rules.
module tb_hazard_ctrl;

    localparam int TB_TIMEOUT = 4;
    localparam int TB_CNT_W   = 4;
    localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [4:0]          ID_RS1, ID_RS2;
    logic                ID_BRANCH, ID_JUMPR, ID_MEM_WRITE, ID_I_TYPE;
    logic [4:0]          ID_EX_RD;
    logic                ID_EX_REG_WRITE, ID_EX_MEM_READ;
    logic [4:0]          EX_MEM_RD;
    logic                EX_MEM_REG_WRITE, EX_MEM_MEM_READ, EX_MEM_LWCP;
    logic                CP_ACK;
    logic                STALL, PC_HOLD, FORWARD_DECODE_A, FORWARD_DECODE_B;
    logic                LWCP_STALL, CP_REQ, CP_ERR;
    logic [TB_CNT_W-1:0] STALL_CNT;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_BRANCH(ID_BRANCH), .ID_JUMPR(ID_JUMPR),
        .ID_MEM_WRITE(ID_MEM_WRITE), .ID_I_TYPE(ID_I_TYPE),
        .ID_EX_RD(ID_EX_RD), .ID_EX_REG_WRITE(ID_EX_REG_WRITE),
        .ID_EX_MEM_READ(ID_EX_MEM_READ),
        .EX_MEM_RD(EX_MEM_RD), .EX_MEM_REG_WRITE(EX_MEM_REG_WRITE),
        .EX_MEM_MEM_READ(EX_MEM_MEM_READ), .EX_MEM_LWCP(EX_MEM_LWCP),
        .CP_ACK(CP_ACK),
        .STALL(STALL), .PC_HOLD(PC_HOLD),
        .FORWARD_DECODE_A(FORWARD_DECODE_A), .FORWARD_DECODE_B(FORWARD_DECODE_B),
        .LWCP_STALL(LWCP_STALL), .CP_REQ(CP_REQ), .CP_ERR(CP_ERR),
        .STALL_CNT(STALL_CNT)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic clearInputs();
        ID_RS1 = 5'd0; ID_RS2 = 5'd0;
        ID_BRANCH = 1'b0; ID_JUMPR = 1'b0; ID_MEM_WRITE = 1'b0; ID_I_TYPE = 1'b0;
        ID_EX_RD = 5'd0; ID_EX_REG_WRITE = 1'b0; ID_EX_MEM_READ = 1'b0;
        EX_MEM_RD = 5'd0; EX_MEM_REG_WRITE = 1'b0; EX_MEM_MEM_READ = 1'b0;
        EX_MEM_LWCP = 1'b0; CP_ACK = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        clearInputs();
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
    endtask

    // R-type instruction in decode reading rd of a load sitting in EX.
    task automatic driveLoadUse(input logic [4:0] rd);
        ID_RS1 = 5'd1; ID_RS2 = 5'd5; ID_I_TYPE = 1'b0; ID_BRANCH = 1'b0;
        ID_JUMPR = 1'b0; ID_EX_RD = rd; ID_EX_REG_WRITE = 1'b1; ID_EX_MEM_READ = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        driveLoadUse(5'd5);
        EX_MEM_LWCP = 1'b1; EX_MEM_RD = 5'd1; EX_MEM_REG_WRITE = 1'b1;
        #1;
        checks++;
        if ({STALL, PC_HOLD, FORWARD_DECODE_A, FORWARD_DECODE_B, LWCP_STALL, CP_REQ} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_comb: got %b expected 000000",
                     {STALL, PC_HOLD, FORWARD_DECODE_A, FORWARD_DECODE_B, LWCP_STALL, CP_REQ});
        end
        nextCycle();
        checks++;
        if (STALL_CNT !== 4'd0 || CP_ERR !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_regs: got cnt=%0d err=%b expected cnt=0 err=0", STALL_CNT, CP_ERR);
        end
        rst_n = 1'b1;
        clearInputs();
    endtask

    task automatic test_load_use();
        doReset();
        driveLoadUse(5'd5);
        #1;
        checks++;
        if (STALL !== 1'b1 || PC_HOLD !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_use_stall: got stall=%b hold=%b expected 1 1", STALL, PC_HOLD);
        end
        nextCycle();
        clearInputs();
        ID_RS1 = 5'd1; ID_RS2 = 5'd5;
        EX_MEM_RD = 5'd5; EX_MEM_REG_WRITE = 1'b1; EX_MEM_MEM_READ = 1'b1;
        #1;
        checks++;
        if (STALL !== 1'b0 || FORWARD_DECODE_B !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_use_release: got stall=%b fwdB=%b expected 0 0", STALL, FORWARD_DECODE_B);
        end
        nextCycle();
        clearInputs();
        driveLoadUse(5'd0);
        ID_RS2 = 5'd0;
        #1;
        checks++;
        if (STALL !== 1'b0 || STALL_CNT !== 4'd1) begin
            failures++;
            $display("[TB] FAIL load_use_x0: got stall=%b cnt=%0d expected 0 1", STALL, STALL_CNT);
        end
    endtask

    task automatic test_branch_alu();
        doReset();
        ID_BRANCH = 1'b1; ID_RS1 = 5'd7; ID_RS2 = 5'd2; ID_I_TYPE = 1'b0;
        ID_EX_RD = 5'd7; ID_EX_REG_WRITE = 1'b1;
        #1;
        checks++;
        if (STALL !== 1'b1) begin
            failures++;
            $display("[TB] FAIL branch_alu_stall: got %b expected 1", STALL);
        end
        nextCycle();
        ID_EX_RD = 5'd0; ID_EX_REG_WRITE = 1'b0;
        EX_MEM_RD = 5'd7; EX_MEM_REG_WRITE = 1'b1;
        #1;
        checks++;
        if (FORWARD_DECODE_A !== 1'b1 || FORWARD_DECODE_B !== 1'b0 || STALL !== 1'b0) begin
            failures++;
            $display("[TB] FAIL branch_alu_fwd: got fwdA=%b fwdB=%b stall=%b expected 1 0 0",
                     FORWARD_DECODE_A, FORWARD_DECODE_B, STALL);
        end
        nextCycle();
        clearInputs();
    endtask

    task automatic test_branch_load();
        int stallCycles = 0;
        int fwdSeen = 0;
        doReset();
        for (int cyc = 0; cyc < 4; cyc++) begin
            clearInputs();
            ID_BRANCH = 1'b1; ID_RS1 = 5'd4; ID_RS2 = 5'd3;
            if (cyc == 0) begin
                ID_EX_RD = 5'd3; ID_EX_REG_WRITE = 1'b1; ID_EX_MEM_READ = 1'b1;
            end else if (cyc == 1) begin
                EX_MEM_RD = 5'd3; EX_MEM_REG_WRITE = 1'b1; EX_MEM_MEM_READ = 1'b1;
            end
            #1;
            if (STALL) stallCycles++;
            if (FORWARD_DECODE_B) fwdSeen++;
            nextCycle();
        end
        checks++;
        if (stallCycles != 2 || fwdSeen != 0) begin
            failures++;
            $display("[TB] FAIL branch_load: got stalls=%0d fwdB=%0d expected 2 0", stallCycles, fwdSeen);
        end
        checks++;
        if (STALL_CNT !== 4'd2) begin
            failures++;
            $display("[TB] FAIL branch_load_cnt: got %0d expected 2", STALL_CNT);
        end
        clearInputs();
    endtask

    task automatic test_lwcp_normal();
        int freezeCycles = 0;
        int reqCycles = 0;
        doReset();
        for (int cyc = 0; cyc < 7; cyc++) begin
            EX_MEM_LWCP = (cyc == 0);
            CP_ACK = (cyc == 5);
            #1;
            if (LWCP_STALL) freezeCycles++;
            if (CP_REQ) reqCycles++;
            if (cyc == 0) begin
                checks++;
                if (CP_REQ !== 1'b0 || LWCP_STALL !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL lwcp_detect: got req=%b freeze=%b expected 0 1", CP_REQ, LWCP_STALL);
                end
            end
            if (cyc == 1) begin
                checks++;
                if (CP_REQ !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL lwcp_req_latency: got %b expected 1", CP_REQ);
                end
            end
            nextCycle();
        end
        CP_ACK = 1'b0;
        driveLoadUse(5'd5);
        #1;
        checks++;
        if (freezeCycles != 6 || reqCycles != 5) begin
            failures++;
            $display("[TB] FAIL lwcp_normal_len: got freeze=%0d req=%0d expected 6 5", freezeCycles, reqCycles);
        end
        checks++;
        if (CP_ERR !== 1'b0 || STALL_CNT !== 4'd6) begin
            failures++;
            $display("[TB] FAIL lwcp_normal_regs: got err=%b cnt=%0d expected 0 6", CP_ERR, STALL_CNT);
        end
        checks++;
        if (STALL !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lwcp_after_hazard: got %b expected 1", STALL);
        end
        nextCycle();
        clearInputs();
    endtask

    task automatic test_lwcp_timeout();
        doReset();
        for (int cyc = 0; cyc < 8; cyc++) begin
            EX_MEM_LWCP = (cyc == 0);
            CP_ACK = 1'b0;
            #1;
            if (cyc == 5) begin
                checks++;
                if (CP_ERR !== 1'b0 || CP_REQ !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL timeout_last_wait: got err=%b req=%b expected 0 1", CP_ERR, CP_REQ);
                end
            end
            if (cyc == 6) begin
                checks++;
                if (CP_ERR !== 1'b1 || CP_REQ !== 1'b0 || LWCP_STALL !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL timeout_done: got err=%b req=%b freeze=%b expected 1 0 0",
                             CP_ERR, CP_REQ, LWCP_STALL);
                end
            end
            nextCycle();
        end
        for (int cyc = 0; cyc < 3; cyc++) begin
            CP_ACK = 1'b1;
            #1;
            checks++;
            if (CP_REQ !== 1'b0 || LWCP_STALL !== 1'b0 || CP_ERR !== 1'b1) begin
                failures++;
                $display("[TB] FAIL timeout_late_ack: got req=%b freeze=%b err=%b expected 0 0 1",
                         CP_REQ, LWCP_STALL, CP_ERR);
            end
            nextCycle();
        end
        CP_ACK = 1'b0;
        EX_MEM_LWCP = 1'b1;
        #1;
        checks++;
        if (LWCP_STALL !== 1'b1 || STALL_CNT !== 4'd6) begin
            failures++;
            $display("[TB] FAIL timeout_retrigger: got freeze=%b cnt=%0d expected 1 6", LWCP_STALL, STALL_CNT);
        end
        nextCycle();
        clearInputs();
    endtask

    task automatic test_reset_mid_wait();
        doReset();
        for (int cyc = 0; cyc < 4; cyc++) begin
            driveLoadUse(5'd5);
            EX_MEM_LWCP = (cyc == 0);
            #1;
            checks++;
            if (STALL !== 1'b0 || PC_HOLD !== 1'b0 || LWCP_STALL !== 1'b1) begin
                failures++;
                $display("[TB] FAIL freeze_beats_hazard cyc%0d: got stall=%b hold=%b freeze=%b expected 0 0 1",
                         cyc, STALL, PC_HOLD, LWCP_STALL);
            end
            nextCycle();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({STALL, PC_HOLD, LWCP_STALL, CP_REQ} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_wait_comb: got %b expected 0000", {STALL, PC_HOLD, LWCP_STALL, CP_REQ});
        end
        nextCycle();
        rst_n = 1'b1;
        clearInputs();
        #1;
        checks++;
        if ({STALL, PC_HOLD, FORWARD_DECODE_A, FORWARD_DECODE_B, LWCP_STALL, CP_REQ, CP_ERR} !== 7'b0
            || STALL_CNT !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_wait_after: got outs=%b cnt=%0d expected 0000000 0",
                     {STALL, PC_HOLD, FORWARD_DECODE_A, FORWARD_DECODE_B, LWCP_STALL, CP_REQ, CP_ERR},
                     STALL_CNT);
        end
    endtask

    task automatic test_saturation();
        doReset();
        driveLoadUse(5'd5);
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (cyc == 15 || cyc == 19) begin
                checks++;
                if (STALL_CNT !== 4'd15) begin
                    failures++;
                    $display("[TB] FAIL cnt_saturate cyc%0d: got %0d expected 15", cyc, STALL_CNT);
                end
            end
            nextCycle();
        end
        clearInputs();
    endtask

    // Random stimulus compared against a model of the rules: lwcpAge is -1
    // when no coprocessor transfer is outstanding, 0 on the request cycle and
    // k on the k-th waiting cycle; releasing marks the one-cycle hand-back.
    task automatic test_random();
        int  lwcpAge = -1;
        bit  releasing = 0;
        bit  mErr = 0;
        int  mCnt = 0;
        logic [4:0] src [2];
        bit  used [2];
        bit  fwd [2];
        bit  ctrlFlow, exHit, memHit, expFreeze, expReq, expStall;
        doReset();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            ID_RS1 = 5'($urandom_range(0, 3));
            ID_RS2 = 5'($urandom_range(0, 3));
            ID_BRANCH = 1'($urandom_range(0, 1));
            ID_JUMPR = 1'($urandom_range(0, 1));
            ID_MEM_WRITE = 1'($urandom_range(0, 1));
            ID_I_TYPE = 1'($urandom_range(0, 1));
            ID_EX_RD = 5'($urandom_range(0, 3));
            ID_EX_REG_WRITE = 1'($urandom_range(0, 1));
            ID_EX_MEM_READ = 1'($urandom_range(0, 1));
            EX_MEM_RD = 5'($urandom_range(0, 3));
            EX_MEM_REG_WRITE = 1'($urandom_range(0, 1));
            EX_MEM_MEM_READ = 1'($urandom_range(0, 1));
            EX_MEM_LWCP = ($urandom_range(0, 7) == 0);
            CP_ACK = ($urandom_range(0, 3) == 0);
            #1;
            src[0] = ID_RS1; used[0] = 1'b1;
            src[1] = ID_RS2; used[1] = ID_BRANCH || ID_MEM_WRITE || (!ID_I_TYPE && !ID_JUMPR);
            ctrlFlow = ID_BRANCH || ID_JUMPR;
            exHit = 0; memHit = 0;
            for (int s = 0; s < 2; s++) begin
                fwd[s] = EX_MEM_REG_WRITE && !EX_MEM_MEM_READ && src[s] != 0 && src[s] == EX_MEM_RD;
                if (used[s] && src[s] != 0) begin
                    if (ID_EX_REG_WRITE && src[s] == ID_EX_RD && (ctrlFlow || ID_EX_MEM_READ)) exHit = 1;
                    if (ctrlFlow && EX_MEM_MEM_READ && src[s] == EX_MEM_RD) memHit = 1;
                end
            end
            expFreeze = rst_n && (lwcpAge >= 0 || (!releasing && EX_MEM_LWCP));
            expReq    = rst_n && (lwcpAge >= 0);
            expStall  = rst_n && (exHit || memHit) && !expFreeze;
            checks++;
            if ({STALL, PC_HOLD, FORWARD_DECODE_A, FORWARD_DECODE_B, LWCP_STALL, CP_REQ}
                !== {expStall, expStall, rst_n && fwd[0], rst_n && fwd[1], expFreeze, expReq}) begin
                failures++;
                $display("[TB] FAIL random_comb i=%0d: got %b expected %b", i,
                         {STALL, PC_HOLD, FORWARD_DECODE_A, FORWARD_DECODE_B, LWCP_STALL, CP_REQ},
                         {expStall, expStall, rst_n && fwd[0], rst_n && fwd[1], expFreeze, expReq});
            end
            checks++;
            if (CP_ERR !== mErr || int'(STALL_CNT) != mCnt) begin
                failures++;
                $display("[TB] FAIL random_regs i=%0d: got err=%b cnt=%0d expected err=%b cnt=%0d",
                         i, CP_ERR, STALL_CNT, mErr, mCnt);
            end
            if (!rst_n) begin
                lwcpAge = -1; releasing = 0; mErr = 0; mCnt = 0;
            end else begin
                if ((expStall || expFreeze) && mCnt < CNT_MAX) mCnt++;
                if (releasing) begin
                    releasing = 0;
                end else if (lwcpAge < 0) begin
                    if (EX_MEM_LWCP) lwcpAge = 0;
                end else if (lwcpAge == 0) begin
                    lwcpAge = 1;
                end else if (CP_ACK) begin
                    lwcpAge = -1; releasing = 1;
                end else if (lwcpAge == TB_TIMEOUT) begin
                    mErr = 1; lwcpAge = -1; releasing = 1;
                end else begin
                    lwcpAge++;
                end
            end
            nextCycle();
        end
        rst_n = 1'b1;
        clearInputs();
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        clearInputs();
        rst_n = 1'b0;
        nextCycle();
        test_reset();
        test_load_use();
        test_branch_alu();
        test_branch_load();
        test_lwcp_normal();
        test_lwcp_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
